// File: rtl/ej5_exhaustive_checker.sv
// Exhaustive equivalence checker for the ej5 logic block: sweeps every {A,B,C} vector and
// compares canonical against simplified outputs after a programmable settle time.
module ej5_exhaustive_checker #(
  parameter int unsigned IN_W      = 3,
  parameter int unsigned OUT_PAIRS = 4,
  parameter int unsigned SETTLE    = 2   // must be >= 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [IN_W-1:0]      stim,
  input  logic [OUT_PAIRS-1:0] ref_out,
  input  logic [OUT_PAIRS-1:0] alt_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [IN_W:0]        err_count,
  output logic [IN_W-1:0]      first_err_vec,
  output logic [OUT_PAIRS-1:0] first_err_mask
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);
  localparam logic [IN_W-1:0] LastVec = {IN_W{1'b1}};

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSettle  = 2'd1;
  localparam logic [1:0] StCompare = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IN_W-1:0]      stim_q, stim_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [IN_W:0]        err_q, err_d;
  logic [IN_W-1:0]      fvec_q, fvec_d;
  logic [OUT_PAIRS-1:0] fmask_q, fmask_d;
  logic [OUT_PAIRS-1:0] mism;

  assign mism = ref_out ^ alt_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fmask_d = fmask_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StSettle;
          stim_d  = '0;
          cnt_d   = CntLoad;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fvec_d  = '0;
          fmask_d = '0;
        end
      end

      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StCompare;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StCompare: begin
        if (|mism) begin
          err_d = err_q + 1'b1;
          // Only the first failing vector is captured; later ones just count.
          if (err_q == '0) begin
            fvec_d  = stim_q;
            fmask_d = mism;
          end
        end
        if (stim_q == LastVec) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = StSettle;
          stim_d  = stim_q + 1'b1;
          cnt_d   = CntLoad;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fmask_q <= fmask_d;
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_vec  = fvec_q;
  assign first_err_mask = fmask_q;

endmodule
